// File: rtl/timer_pkg.sv
// Shared time-field widths, limits and state encoding for the clock/timer
// subsystem (countdown timer and stopwatch).
package timer_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
  localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;
  localparam logic [SEC_W-1:0]  MAX_SEC  = 6'd59;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAUSED  = 2'd1,
    RUN     = 2'd2,
    EXPIRED = 2'd3
  } timer_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the enabled clock down to one tick per counted second.
// The counter holds its value while en is low, so a paused count resumes
// part-way through the second it was paused in.
module tick_prescaler #(
  parameter int unsigned TICKS_PER_SEC = 1
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] count;

  // A tick fires on the enabled edge where the counter sits at its last value.
  assign tick = en && (count == LAST);

  // Prescaler counter: clear wins, otherwise count and wrap while enabled.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count <= {CNT_W{1'b0}};
    end else if (clr) begin
      count <= {CNT_W{1'b0}};
    end else if (en) begin
      if (count == LAST) begin
        count <= {CNT_W{1'b0}};
      end else begin
        count <= count + CNT_W'(1);
      end
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// HH:MM:SS countdown timer. Loads through the Timeset interface, counts down
// to 00:00:00 one second per prescaler tick, and flags expiry with a
// one-cycle done pulse plus a sticky expired flag.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 1
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_stop,
  input  logic              Timeset,
  input  logic [HOUR_W-1:0] Hourset,
  input  logic [MIN_W-1:0]  Minset,
  input  logic [SEC_W-1:0]  Secset,
  output logic [HOUR_W-1:0] hour_o,
  output logic [MIN_W-1:0]  min_o,
  output logic [SEC_W-1:0]  sec_o,
  output logic              running_o,
  output logic              done_o,
  output logic              expired_o
);

  timer_state_e      state;
  timer_state_e      next_state;
  logic [HOUR_W-1:0] next_hour;
  logic [MIN_W-1:0]  next_min;
  logic [SEC_W-1:0]  next_sec;
  logic              next_running;
  logic              next_done;
  logic              next_expired;

  logic [HOUR_W-1:0] load_hour;
  logic [MIN_W-1:0]  load_min;
  logic [SEC_W-1:0]  load_sec;
  logic              load_zero;
  logic              at_one_sec;
  logic              presc_en;
  logic              tick;

  function automatic logic [HOUR_W-1:0] clamp_hour(input logic [HOUR_W-1:0] v);
    return (v > MAX_HOUR) ? MAX_HOUR : v;
  endfunction

  // Minutes and seconds share width and limit.
  function automatic logic [MIN_W-1:0] clamp_sixty(input logic [MIN_W-1:0] v);
    return (v > MAX_MIN) ? MAX_MIN : v;
  endfunction

  assign load_hour  = clamp_hour(Hourset);
  assign load_min   = clamp_sixty(Minset);
  assign load_sec   = clamp_sixty(Secset);
  assign load_zero  = (load_hour == 5'd0) && (load_min == 6'd0) && (load_sec == 6'd0);
  assign at_one_sec = (hour_o == 5'd0) && (min_o == 6'd0) && (sec_o == 6'd1);

  // The prescaler only advances on edges that stay in RUN.
  assign presc_en = (state == RUN) && start_stop && !Timeset;

  tick_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .en      (presc_en),
    .clr     (Timeset),
    .tick    (tick)
  );

  // Next-state, borrow chain and flag logic; Timeset overrides every state.
  always_comb begin
    next_state   = state;
    next_hour    = hour_o;
    next_min     = min_o;
    next_sec     = sec_o;
    next_done    = 1'b0;
    next_expired = expired_o;
    if (Timeset) begin
      next_hour    = load_hour;
      next_min     = load_min;
      next_sec     = load_sec;
      next_expired = 1'b0;
      next_state   = load_zero ? IDLE : PAUSED;
    end else begin
      case (state)
        IDLE: begin
          next_state = IDLE;
        end
        PAUSED: begin
          if (start_stop) begin
            next_state = RUN;
          end else begin
            next_state = PAUSED;
          end
        end
        RUN: begin
          if (!start_stop) begin
            next_state = PAUSED;
          end else if (tick) begin
            if (sec_o != 6'd0) begin
              next_sec = sec_o - 6'd1;
            end else if (min_o != 6'd0) begin
              next_min = min_o - 6'd1;
              next_sec = MAX_SEC;
            end else if (hour_o != 5'd0) begin
              next_hour = hour_o - 5'd1;
              next_min  = MAX_MIN;
              next_sec  = MAX_SEC;
            end else begin
              next_sec = sec_o;
            end
            if (at_one_sec) begin
              next_done    = 1'b1;
              next_expired = 1'b1;
              next_state   = EXPIRED;
            end else begin
              next_state = RUN;
            end
          end else begin
            next_state = RUN;
          end
        end
        EXPIRED: begin
          next_state = EXPIRED;
        end
        default: begin
          next_state = IDLE;
        end
      endcase
    end
    next_running = (next_state == RUN);
  end

  // State and all outputs are registered together.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state     <= IDLE;
      hour_o    <= 5'd0;
      min_o     <= 6'd0;
      sec_o     <= 6'd0;
      running_o <= 1'b0;
      done_o    <= 1'b0;
      expired_o <= 1'b0;
    end else begin
      state     <= next_state;
      hour_o    <= next_hour;
      min_o     <= next_min;
      sec_o     <= next_sec;
      running_o <= next_running;
      done_o    <= next_done;
      expired_o <= next_expired;
    end
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Down-counting companion to the up-counting stopwatch: loads an HH:MM:SS value through the same Timeset/Hourset/Minset/Secset interface and counts down to 00:00:00.
- Flags expiry with a one-cycle pulse and a sticky flag.
- Sits beside the stopwatch in the clock/timer subsystem and shares its time-field widths and display outputs.

Parameters:
- TICKS_PER_SEC, 1: clk_i cycles per counted second; 1 means every enabled clock edge is one second. Must be >= 1.

Ports:
- clk_i  in  1  system clock
- reset_ni  in  1  asynchronous, active-low reset
- start_stop  in  1  level; 1 = run, 0 = pause
- Timeset  in  1  level; while 1, load the set fields every cycle
- Hourset  in  5  hours to load
- Minset  in  6  minutes to load
- Secset  in  6  seconds to load
- hour_o  out  5  current hours remaining
- min_o  out  6  current minutes remaining
- sec_o  out  6  current seconds remaining
- running_o  out  1  1 while in RUN
- done_o  out  1  one-cycle pulse on reaching 00:00:00 by counting
- expired_o  out  1  sticky expiry flag

Behaviour:
- Reset (reset_ni=0, asynchronous): state IDLE; hour_o, min_o and sec_o are all 0; running_o=0; done_o=0; expired_o=0; prescaler=0.
- All outputs are registered. Everything else updates on the rising edge of clk_i.
- States are IDLE (time zero, nothing to count), PAUSED, RUN and EXPIRED.
- Timeset=1 has highest priority in every state:
  - loads clamped fields: Hourset>23 loads 23; Minset>59 loads 59; Secset>59 loads 59;
  - clears expired_o and the prescaler; done_o=0;
  - next state is IDLE if the loaded value is 00:00:00, otherwise PAUSED;
  - no decrement occurs while Timeset=1, regardless of start_stop.
- IDLE: start_stop is ignored and the time holds at zero.
- PAUSED: if start_stop=1 and Timeset=0, go to RUN on that edge, with no decrement on the transition edge. Otherwise hold; the prescaler value is retained.
- RUN:
  - start_stop=0: go to PAUSED with no decrement that edge.
  - Otherwise the prescaler increments. When it equals TICKS_PER_SEC-1 it wraps to 0 and a tick occurs on that edge.
  - With TICKS_PER_SEC=1 a tick occurs on every RUN edge, so the first decrement lands on the second edge after start_stop rises from PAUSED.
- Decrement on tick:
  - sec>0: sec-1;
  - else min>0: min-1, sec=59;
  - else hour>0: hour-1, min=59, sec=59.
- Expiry: a tick from 00:00:01 writes 00:00:00 and, on the same edge, sets done_o=1 and expired_o=1 and moves to EXPIRED. done_o returns to 0 on the next edge.
- EXPIRED: holds 00:00:00; start_stop is ignored; expired_o stays 1 until Timeset or reset.
- Loading 00:00:00 never raises done_o or expired_o.
- running_o = (state==RUN), registered alongside the state.
- A reset mid-count aborts immediately to reset values; no done_o is produced.

Decomposition:
- Shared package timer_pkg holds:
  - widths HOUR_W=5, MIN_W=6, SEC_W=6;
  - constants MAX_HOUR=23, MAX_MIN=59, MAX_SEC=59;
  - a state enum {IDLE, PAUSED, RUN, EXPIRED}.
  - The stopwatch is to use the same constants.
- One natural sub-module, tick_prescaler: counter of width clog2(TICKS_PER_SEC) (minimum 1 bit), with inputs en and clr and output tick. It is instantiated once.
- The clamp logic and the borrow chain stay in countdown_timer.

Test Plan:
- Load and count, TICKS_PER_SEC=1:
  - Stimulus: Timeset=1 with 00:00:03, then Timeset=0, start_stop=1.
  - Response: outputs read 3, 2, 1, 0 on successive edges after RUN entry; done_o is high exactly one cycle together with 00:00:00; expired_o stays 1; running_o drops.
- Borrow chain:
  - Stimulus: load 01:00:00 and run 1 tick.
  - Response: 00:59:59. Then load 00:01:00 and run 1 tick; response: 00:00:59.
- Clamp:
  - Stimulus: load Hourset=31, Minset=63, Secset=60.
  - Response: reads 23:59:59 and the state is PAUSED.
- Pause and resume:
  - Stimulus: load 00:00:10, run 3 ticks, start_stop=0 for 5 cycles, then start_stop=1.
  - Response: holds 00:00:07 during the pause; counts 6, 5, … after resume; running_o tracks the pause.
- Zero load and reload:
  - Stimulus A: load 00:00:00 with start_stop=1. Response: stays IDLE with no done_o.
  - Stimulus B: after an expiry, assert Timeset with 00:00:02. Response: expired_o clears and counting restarts.
- Prescaler and async reset:
  - Stimulus: TICKS_PER_SEC=4, load 00:00:02 and run.
  - Response: decrements every 4 cycles.
  - Stimulus: pull reset_ni low mid-count, between clock edges.
  - Response: outputs go to 0 immediately, with no done_o.
